// File: rtl/wired0_defines.sv
// Shared types for the commit stage: ROB entry layout, exception code and commit FSM states.
`ifndef _WIRED_PARAM_ROB_LEN
`define _WIRED_PARAM_ROB_LEN 6
`endif

package wired0_defines;

  localparam int unsigned ROB_LEN_DEFAULT = `_WIRED_PARAM_ROB_LEN;

  typedef logic [ROB_LEN_DEFAULT-1:0] rob_rid_t;
  typedef logic [5:0] excp_t;

  typedef struct packed {
    logic [4:0]  wreg;
    logic [31:0] pc;
    logic        store_buffer;
  } rob_static_t;

  typedef struct packed {
    logic        excp;
    excp_t       excp_code;
    logic        need_jump;
    logic [31:0] jump_target;
    logic        uncached;
    logic        store_conditional;
  } rob_dynamic_t;

  typedef struct packed {
    rob_static_t  static_info;
    logic [31:0]  data;
    rob_dynamic_t dynamic_info;
  } rob_entry_t;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } commit_state_e;

endpackage

// File: rtl/wired_commit_slot_chk.sv
// Per-slot commit eligibility and special-entry decode for one of the two oldest ROB entries.
module wired_commit_slot_chk
  import wired0_defines::*;
(
  input  rob_entry_t  entry_i,
  input  logic        valid_i,
  input  logic        sb_ready_i,
  output logic        ready_o,
  output logic        special_o,
  output logic        excp_o,
  output logic        store_o,
  output logic        need_sb_o,
  output logic [31:0] redirect_pc_o
);

  always_comb begin
    need_sb_o = entry_i.static_info.store_buffer;
    store_o   = entry_i.static_info.store_buffer | entry_i.dynamic_info.store_conditional;
    excp_o    = entry_i.dynamic_info.excp;
    special_o = entry_i.dynamic_info.excp | entry_i.dynamic_info.need_jump |
                entry_i.dynamic_info.uncached;
    ready_o   = valid_i & (~need_sb_o | sb_ready_i);
    // Exceptions report their own pc to the CSR; uncached ops restart just after themselves.
    if (entry_i.dynamic_info.excp)
      redirect_pc_o = entry_i.static_info.pc;
    else if (entry_i.dynamic_info.need_jump)
      redirect_pc_o = entry_i.dynamic_info.jump_target;
    else
      redirect_pc_o = entry_i.static_info.pc + 32'd4;
  end

endmodule

// File: rtl/wired_commit.sv
// In-order ROB commit controller: retires up to two entries per cycle and drains after a redirect.
// Define WIRED_COMMIT_PERF_EN to add the perf_retired_o / perf_flush_o counters.
module wired_commit
  import wired0_defines::*;
#(
  parameter int unsigned ROB_LEN = `_WIRED_PARAM_ROB_LEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               p_alloc_i,
  output logic                     c_stall_o,
  output logic [1:0][ROB_LEN-1:0]  c_rrrid_o,
  input  logic [1:0]               c_rob_valid_i,
  input  rob_entry_t [1:0]         c_rob_entry_i,
  output logic [1:0]               c_retire_o,
  output logic                     c_drain_o,
  input  logic                     c_sb_ready_i,
  output logic                     c_sb_commit_o,
  output logic [1:0]               c_arf_we_o,
  output logic [1:0][4:0]          c_arf_waddr_o,
  output logic [1:0][31:0]         c_arf_wdata_o,
  output logic                     c_flush_o,
  output logic [31:0]              c_redirect_pc_o,
  output logic                     c_excp_valid_o,
  output excp_t                    c_excp_code_o
`ifdef WIRED_COMMIT_PERF_EN
  ,
  output logic [31:0]              perf_retired_o,
  output logic [31:0]              perf_flush_o
`endif
);

  localparam int unsigned DEPTH = 1 << ROB_LEN;
  localparam logic [ROB_LEN:0] OCC_TWO = (ROB_LEN+1)'(2);
  localparam logic [ROB_LEN:0] OCC_HI  = (ROB_LEN+1)'(DEPTH - 2);

  commit_state_e        state_q, state_d;
  logic [ROB_LEN-1:0]   head_q, head_d;
  logic [ROB_LEN:0]     occ_q, occ_d;
  logic [1:0]           arf_we_q, arf_we_d;
  logic [1:0][4:0]      arf_waddr_q, arf_waddr_d;
  logic [1:0][31:0]     arf_wdata_q, arf_wdata_d;
  logic                 flush_q, flush_d;
  logic [31:0]          redirect_q, redirect_d;
  logic                 excp_valid_q, excp_valid_d;
  excp_t                excp_code_q, excp_code_d;

  logic [1:0]           rdy, spc, exc, sto, nsb;
  logic [1:0][31:0]     tgt;
  logic [1:0]           retire;
  logic [1:0]           ret_cnt, alloc_cnt;
  logic                 drain, flush, sel;

  for (genvar i = 0; i < 2; i++) begin : g_slot
    wired_commit_slot_chk u_chk (
      .entry_i       (c_rob_entry_i[i]),
      .valid_i       (c_rob_valid_i[i]),
      .sb_ready_i    (c_sb_ready_i),
      .ready_o       (rdy[i]),
      .special_o     (spc[i]),
      .excp_o        (exc[i]),
      .store_o       (sto[i]),
      .need_sb_o     (nsb[i]),
      .redirect_pc_o (tgt[i])
    );
  end

  always_comb begin
    drain  = (state_q == DRAIN);
    retire = 2'b00;
    if (drain) begin
      retire[0] = (occ_q != '0);
      retire[1] = (occ_q >= OCC_TWO);
    end else begin
      retire[0] = (occ_q != '0) & rdy[0];
      // Specials only ever leave through slot 0, alone; one store-buffer port per cycle.
      retire[1] = retire[0] & (occ_q >= OCC_TWO) & rdy[1] & ~spc[0] & ~spc[1] &
                  ~(sto[0] & sto[1]);
    end

    flush         = ~drain & |(retire & spc);
    c_sb_commit_o = ~drain & |(retire & nsb);
    sel           = retire[1] & spc[1];

    ret_cnt   = {1'b0, retire[1]} + {1'b0, retire[0]};
    alloc_cnt = {1'b0, p_alloc_i[1]} + {1'b0, p_alloc_i[0]};
    occ_d     = occ_q + (ROB_LEN+1)'(alloc_cnt) - (ROB_LEN+1)'(ret_cnt);
    head_d    = head_q + ROB_LEN'(ret_cnt);

    state_d = state_q;
    case (state_q)
      NORMAL:  if (flush) state_d = DRAIN;
      DRAIN:   if (occ_d == '0) state_d = NORMAL;
      default: state_d = NORMAL;
    endcase

    arf_we_d = retire & ~exc & {2{~drain}};
    for (int i = 0; i < 2; i++) begin
      arf_waddr_d[i] = arf_we_d[i] ? c_rob_entry_i[i].static_info.wreg : 5'd0;
      arf_wdata_d[i] = arf_we_d[i] ? c_rob_entry_i[i].data : 32'd0;
    end

    flush_d      = flush;
    redirect_d   = flush ? tgt[sel] : 32'd0;
    excp_valid_d = flush & exc[sel];
    excp_code_d  = (flush & exc[sel]) ? c_rob_entry_i[sel].dynamic_info.excp_code : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= NORMAL;
      head_q       <= '0;
      occ_q        <= '0;
      arf_we_q     <= '0;
      arf_waddr_q  <= '0;
      arf_wdata_q  <= '0;
      flush_q      <= 1'b0;
      redirect_q   <= '0;
      excp_valid_q <= 1'b0;
      excp_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      occ_q        <= occ_d;
      arf_we_q     <= arf_we_d;
      arf_waddr_q  <= arf_waddr_d;
      arf_wdata_q  <= arf_wdata_d;
      flush_q      <= flush_d;
      redirect_q   <= redirect_d;
      excp_valid_q <= excp_valid_d;
      excp_code_q  <= excp_code_d;
    end
  end

  assign c_retire_o      = retire;
  assign c_drain_o       = drain;
  assign c_stall_o       = drain | (occ_q > OCC_HI);
  assign c_rrrid_o[0]    = head_q;
  assign c_rrrid_o[1]    = head_q + ROB_LEN'(1);
  assign c_arf_we_o      = arf_we_q;
  assign c_arf_waddr_o   = arf_waddr_q;
  assign c_arf_wdata_o   = arf_wdata_q;
  assign c_flush_o       = flush_q;
  assign c_redirect_pc_o = redirect_q;
  assign c_excp_valid_o  = excp_valid_q;
  assign c_excp_code_o   = excp_code_q;

`ifdef WIRED_COMMIT_PERF_EN
  logic [31:0] perf_retired_q, perf_retired_d, perf_flush_q, perf_flush_d;

  always_comb begin
    perf_retired_d = perf_retired_q + (drain ? 32'd0 : 32'(ret_cnt));
    perf_flush_d   = perf_flush_q + 32'(flush);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_retired_q <= '0;
      perf_flush_q   <= '0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_flush_q   <= perf_flush_d;
    end
  end

  assign perf_retired_o = perf_retired_q;
  assign perf_flush_o   = perf_flush_q;
`endif

  a_no_alloc_in_drain: assert property (@(posedge clk) disable iff (rst)
    !(drain && p_alloc_i != 2'b00));
  a_alloc_thermo: assert property (@(posedge clk) disable iff (rst) p_alloc_i != 2'b10);
  a_occ_bound: assert property (@(posedge clk) disable iff (rst)
    occ_d <= (ROB_LEN+1)'(DEPTH));

endmodule
